// File: rtl/ram_fifo_pkg.sv
// Shared helpers for the RAM-backed FIFO controller: pointer wrap and occupancy width.
package ram_fifo_pkg;

  // Increments a pointer and wraps at depth, so non-power-of-2 depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // Occupancy needs one bit more than the address to represent DEPTH+1 words.
  function automatic int unsigned cnt_w(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/RAM_Simple_Dual_Port.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module RAM_Simple_Dual_Port #(
  parameter int unsigned WORD_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DEPTH         = 256,
  parameter bit          READ_NEW_DATA = 1'b0,
  parameter bit          USE_INIT_FILE = 1'b0
) (
  input  logic                  clock,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [WORD_WIDTH-1:0] write_data,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WORD_WIDTH-1:0] read_data
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Init files are loaded by the FPGA flow; contents are uninitialised in this model.
  if (USE_INIT_FILE) begin : g_init_file
  end

  always_ff @(posedge clock) begin
    if (wren) begin
      mem[write_addr] <= write_data;
    end
    if (rden) begin
      if (READ_NEW_DATA && wren && (write_addr == read_addr)) begin
        read_data <= write_data;
      end else begin
        read_data <= mem[read_addr];
      end
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller around a simple dual-port RAM whose read register is the output stage.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned WORD_WIDTH        = 8,
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned DEPTH             = 256,
  parameter int unsigned ALMOST_FULL_LEVEL = DEPTH - 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH:0]     count,
  output logic                    almost_full
);

  localparam int unsigned CNT_W = cnt_w(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      ram_count_q, ram_count_d;
  logic                  out_valid_q, out_valid_d;
  logic                  almost_full_q;
  logic                  wr, rd, pop;

  assign in_ready = (ram_count_q != CNT_W'(DEPTH));
  assign wr       = in_valid & in_ready;
  assign rd       = (ram_count_q != '0) & (~out_valid_q | out_ready);
  assign pop      = out_valid_q & out_ready;

  always_comb begin
    ram_count_d = ram_count_q + CNT_W'(wr) - CNT_W'(rd);
    out_valid_d = out_valid_q;
    if (rd) begin
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_count_q   <= '0;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr_q <= ADDR_WIDTH'(ptr_inc(32'(wr_ptr_q), DEPTH));
      end
      if (rd) begin
        rd_ptr_q <= ADDR_WIDTH'(ptr_inc(32'(rd_ptr_q), DEPTH));
      end
      ram_count_q   <= ram_count_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= (ram_count_d >= CNT_W'(ALMOST_FULL_LEVEL));
    end
  end

  assign out_valid   = out_valid_q;
  assign count       = ram_count_q + CNT_W'(out_valid_q);
  assign almost_full = almost_full_q;

  // rden is held low while the head word waits, so read_data stays stable.
  RAM_Simple_Dual_Port #(
    .WORD_WIDTH    (WORD_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DEPTH         (DEPTH),
    .READ_NEW_DATA (1'b0),
    .USE_INIT_FILE (1'b0)
  ) u_ram (
    .clock      (clock),
    .wren       (wr),
    .write_addr (wr_ptr_q),
    .write_data (in_data),
    .rden       (rd),
    .read_addr  (rd_ptr_q),
    .read_data  (out_data)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl: a DEPTH=4 instance and a non-power-of-2 DEPTH=5 instance.
module tb_ram_fifo_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       flush4, in_valid4, out_ready4;
  logic [7:0] in_data4, out_data4;
  logic       in_ready4, out_valid4, almost_full4;
  logic [2:0] count4;

  logic       flush5, in_valid5, out_ready5;
  logic [7:0] in_data5, out_data5;
  logic       in_ready5, out_valid5, almost_full5;
  logic [3:0] count5;

  ram_fifo_ctrl #(
    .WORD_WIDTH        (8),
    .ADDR_WIDTH        (2),
    .DEPTH             (4),
    .ALMOST_FULL_LEVEL (3)
  ) dut4 (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush4),
    .in_valid    (in_valid4),
    .in_ready    (in_ready4),
    .in_data     (in_data4),
    .out_valid   (out_valid4),
    .out_ready   (out_ready4),
    .out_data    (out_data4),
    .count       (count4),
    .almost_full (almost_full4)
  );

  ram_fifo_ctrl #(
    .WORD_WIDTH        (8),
    .ADDR_WIDTH        (3),
    .DEPTH             (5),
    .ALMOST_FULL_LEVEL (4)
  ) dut5 (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush5),
    .in_valid    (in_valid5),
    .in_ready    (in_ready5),
    .in_data     (in_data5),
    .out_valid   (out_valid5),
    .out_ready   (out_ready5),
    .out_data    (out_data5),
    .count       (count5),
    .almost_full (almost_full5)
  );

  typedef struct {
    logic       rst;
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       chk;
    logic       ir;
    logic       ov;
    logic [2:0] cnt;
    logic       af;
    logic       dchk;
    logic [7:0] dat;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv, input logic [7:0] d,
                              input logic ordy, input logic chk, input logic ir, input logic ov,
                              input logic [2:0] cnt, input logic af, input logic dchk,
                              input logic [7:0] dat);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy; v.chk = chk;
    v.ir = ir; v.ov = ov; v.cnt = cnt; v.af = af; v.dchk = dchk; v.dat = dat;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive4(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid4 = iv; in_data4 = d; out_ready4 = ordy; flush4 = fl;
  endtask

  task automatic drive5(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid5 = iv; in_data5 = d; out_ready5 = ordy;
  endtask

  logic [7:0] q[$];

  initial begin
    reset = 1'b1;
    drive4(1'b0, 8'h00, 1'b0, 1'b0);
    drive5(1'b0, 8'h00, 1'b0);
    flush5 = 1'b0;

    // Outputs are pure state, so each row's expectation is the state before its edge.
    vq.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 5; i++) vq.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(0, 0, 1, 8'hA1, 1, 1, 1, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 8'h00));
    vq.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 0, 1, 8'hA1));
    vq.push_back(mk(0, 0, 1, 8'h10, 0, 1, 1, 0, 0, 0, 0, 8'h00));
    vq.push_back(mk(0, 0, 1, 8'h11, 0, 1, 1, 0, 1, 0, 0, 8'h00));
    vq.push_back(mk(0, 0, 1, 8'h12, 0, 1, 1, 1, 2, 0, 1, 8'h10));
    vq.push_back(mk(0, 0, 1, 8'h13, 0, 1, 1, 1, 3, 0, 1, 8'h10));
    vq.push_back(mk(0, 0, 1, 8'h14, 0, 1, 1, 1, 4, 1, 1, 8'h10));
    vq.push_back(mk(0, 0, 1, 8'h15, 0, 1, 0, 1, 5, 1, 1, 8'h10));
    vq.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 1, 5, 1, 1, 8'h10));

    @(negedge clock);
    foreach (vq[i]) begin
      reset = vq[i].rst;
      drive4(vq[i].iv, vq[i].d, vq[i].ordy, vq[i].fl);
      #1;
      if (vq[i].chk) begin
        cmp($sformatf("v%0d in_ready", i), in_ready4, vq[i].ir);
        cmp($sformatf("v%0d out_valid", i), out_valid4, vq[i].ov);
        cmp($sformatf("v%0d count", i), count4, vq[i].cnt);
        cmp($sformatf("v%0d almost_full", i), almost_full4, vq[i].af);
        if (vq[i].dchk) cmp($sformatf("v%0d out_data", i), out_data4, vq[i].dat);
      end
      next_cycle();
    end

    // Full FIFO, then continuous streaming; the first offered word meets in_ready=0.
    q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    for (int k = 0; k < 20; k++) begin
      drive4(1'b1, 8'(8'h20 + k), 1'b1, 1'b0);
      #1;
      cmp($sformatf("stream%0d out_valid", k), out_valid4, 1);
      cmp($sformatf("stream%0d out_data", k), out_data4, q[0]);
      cmp($sformatf("stream%0d count", k), count4, q.size());
      cmp($sformatf("stream%0d in_ready", k), in_ready4, (k == 0) ? 0 : 1);
      next_cycle();
      void'(q.pop_front());
      if (k != 0) q.push_back(8'(8'h20 + k));
    end
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      drive4(1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      cmp($sformatf("drain%0d out_valid", i), out_valid4, 1);
      cmp($sformatf("drain%0d out_data", i), out_data4, q[0]);
      cmp($sformatf("drain%0d count", i), count4, q.size());
      next_cycle();
      void'(q.pop_front());
    end
    #1;
    cmp("drained out_valid", out_valid4, 0);
    cmp("drained count", count4, 0);
    cmp("drained in_ready", in_ready4, 1);

    // Flush with a concurrent write and pop: everything in flight is discarded.
    drive4(1'b1, 8'h31, 1'b0, 1'b0); next_cycle();
    drive4(1'b1, 8'h32, 1'b0, 1'b0); next_cycle();
    drive4(1'b1, 8'h33, 1'b0, 1'b0); next_cycle();
    drive4(1'b1, 8'hEE, 1'b1, 1'b1);
    #1;
    cmp("preflush count", count4, 3);
    next_cycle();
    drive4(1'b1, 8'h55, 1'b1, 1'b0);
    #1;
    cmp("flush count", count4, 0);
    cmp("flush out_valid", out_valid4, 0);
    cmp("flush almost_full", almost_full4, 0);
    next_cycle();
    drive4(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    cmp("post55 count", count4, 1);
    cmp("post55 out_valid", out_valid4, 0);
    next_cycle();
    #1;
    cmp("emerge55 out_valid", out_valid4, 1);
    cmp("emerge55 out_data", out_data4, 8'h55);
    cmp("emerge55 count", count4, 1);
    next_cycle();
    #1;
    cmp("after55 out_valid", out_valid4, 0);
    cmp("after55 count", count4, 0);

    // DEPTH=5: fill to DEPTH+1 words, then drain in order.
    for (int j = 0; j < 7; j++) begin
      drive5(1'b1, 8'(8'h50 + j), 1'b0);
      next_cycle();
    end
    drive5(1'b0, 8'h00, 1'b0);
    #1;
    cmp("d5 full count", count5, 6);
    cmp("d5 full in_ready", in_ready5, 0);
    cmp("d5 full almost_full", almost_full5, 1);
    for (int i = 0; i < 6; i++) begin
      drive5(1'b0, 8'h00, 1'b1);
      #1;
      cmp($sformatf("d5 drain%0d out_valid", i), out_valid5, 1);
      cmp($sformatf("d5 drain%0d out_data", i), out_data5, 8'(8'h50 + i));
      cmp($sformatf("d5 drain%0d count", i), count5, 6 - i);
      next_cycle();
    end
    #1;
    cmp("d5 drained out_valid", out_valid5, 0);
    cmp("d5 drained count", count5, 0);

    // DEPTH=5: stream 12 words so both pointers wrap past 4 more than once.
    for (int k = 0; k < 14; k++) begin
      drive5(k < 12, 8'(8'h40 + k), 1'b1);
      #1;
      if (k >= 2) begin
        cmp($sformatf("d5 stream%0d out_valid", k), out_valid5, 1);
        cmp($sformatf("d5 stream%0d out_data", k), out_data5, 8'(8'h40 + k - 2));
      end
      next_cycle();
    end
    drive5(1'b0, 8'h00, 1'b1);
    #1;
    cmp("d5 stream end out_valid", out_valid5, 0);
    cmp("d5 stream end count", count5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
